// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous memory between two requesters:
//   port A (6502 core) and port B (debug/program loader). One access is in
//   flight at a time, sequenced IDLE -> ACCESS -> WAIT -> CAPTURE -> IDLE.
//   The served port gets a one-cycle ack; reads also update its rdata.
//
// Ports
//   clk_sys, rst_n                  clock (rising edge), async active-low reset
//   req_x/we_x/addr_x/wdata_x       port x request (x = a, b), held until ack_x
//   ack_x, rdata_x                  one-cycle done pulse, read data (held)
//   busy                            high while an access is in progress
//   mem_en/mem_we/mem_addr/mem_wdata  to memory ena/wea/addra/dina
//   mem_rdata                       from memory douta
//
// Parameters
//   READ_LATENCY  memory edges from the ena edge to valid douta (>= 1)
//   ARB_MODE      0 = round-robin, 1 = fixed priority to port B

module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int ARB_MODE     = 0
) (
  input  logic                  clk_sys,
  input  logic                  rst_n,
  input  logic                  req_a,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic                  ack_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic                  req_b,
  input  logic                  we_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  ack_b,
  output logic [DATA_WIDTH-1:0] rdata_b,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // WAIT lasts READ_LATENCY-1 cycles; the counter is loaded with that minus one.
  localparam int CW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (READ_LATENCY > 1) ? CW'(READ_LATENCY - 2) : '0;

  state_t                  state_q;
  logic                    port_q;   // served port: 0 = A, 1 = B
  logic                    we_q;
  logic                    last_q;   // last granted port: 0 = A, 1 = B
  logic [CW-1:0]           cnt_q;
  logic                    busy_q;
  logic                    mem_en_q;
  logic                    mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic                    ack_a_q;
  logic                    ack_b_q;
  logic [DATA_WIDTH-1:0]   rdata_a_q;
  logic [DATA_WIDTH-1:0]   rdata_b_q;

  // A port in its ack cycle is still showing the request it was just served
  // for, so it is masked to avoid serving it twice.
  logic elig_a, elig_b, grant_any, grant_b;

  always_comb begin
    elig_a    = req_a & ~ack_a_q;
    elig_b    = req_b & ~ack_b_q;
    grant_any = elig_a | elig_b;
    if (ARB_MODE == 1) grant_b = elig_b;
    else               grant_b = elig_b & (~elig_a | ~last_q);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      last_q      <= 1'b1;   // B counts as last, so A wins the first tie
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_a_q     <= 1'b0;
      ack_b_q     <= 1'b0;
      rdata_a_q   <= '0;
      rdata_b_q   <= '0;
    end else begin
      // Enables and acks are single-cycle pulses; default them low.
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            port_q      <= grant_b;
            last_q      <= grant_b;
            we_q        <= grant_b ? we_b    : we_a;
            mem_addr_q  <= grant_b ? addr_b  : addr_a;
            mem_wdata_q <= grant_b ? wdata_b : wdata_a;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_b ? we_b    : we_a;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (READ_LATENCY > 1) begin
            cnt_q   <= CNT_INIT;
            state_q <= WAIT;
          end else begin
            state_q <= CAPTURE;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= CAPTURE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        CAPTURE: begin
          if (port_q) begin
            if (!we_q) rdata_b_q <= mem_rdata;
            ack_b_q <= 1'b1;
          end else begin
            if (!we_q) rdata_a_q <= mem_rdata;
            ack_a_q <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ack_a     = ack_a_q;
  assign ack_b     = ack_b_q;
  assign rdata_a   = rdata_a_q;
  assign rdata_b   = rdata_b_q;

endmodule
